// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 6-digit 7-segment display driver.
package seg7_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [5:0] AN_OFF     = 6'h3F;
    // Digits that carry the HH.MM.SS separators when the colon bit is set
    localparam logic [5:0] DP_DIGITS  = 6'b010100;

    typedef logic [2:0] digit_idx_t;

    localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    localparam int EN_BIT    = 31;
    localparam int COLON_BIT = 30;
    localparam int BLINK_HI  = 29;
    localparam int BLINK_LO  = 24;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high a..g segment decoder (bit 0 = a).
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 6-digit common-anode 7-segment display from a frame-latched PIO word.
// Optional digit blinking is compiled in when DISP_BLINK_EN is defined.
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seg_word,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [5:0]  an_n
);

    localparam int             CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             tick;
    logic             frame;
    logic             suppress;
    logic             active;
    logic [3:0]       nibble;
    logic [6:0]       seg_hi;

    // Outputs are registered from the next-state values so the visible
    // anode/segment pattern always lines up with the slot counter.
    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        frame    = tick && (idx_q == LAST_DIGIT);
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_DIGIT) ? '0 : idx_q + digit_idx_t'(1);
        end
        shadow_d = frame ? seg_word : shadow_q;
        nibble   = shadow_d[{idx_d, 2'b00} +: 4];
    end

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_hi)
    );

`ifdef DISP_BLINK_EN
    localparam int               BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    blink_phase_t       phase_q, phase_d;
    logic [5:0]         blink_mask;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
        blink_mask = shadow_d[BLINK_HI:BLINK_LO];
        suppress   = (phase_d == BLINK_OFF) && blink_mask[idx_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= BLINK_ON;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{shadow_q[BLINK_HI:BLINK_LO], BLINK_FRAMES[0]};
    assign suppress     = 1'b0;
`endif

    always_comb begin
        active = (cnt_d >= CNT_BLANK) && shadow_d[EN_BIT] && !suppress;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_n    <= SEG_OFF;
            dp_n     <= 1'b1;
            an_n     <= AN_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            if (active) begin
                an_n  <= ~(6'b000001 << idx_d);
                seg_n <= ~seg_hi;
                dp_n  <= ~(DP_DIGITS[idx_d] & shadow_d[COLON_BIT]);
            end else begin
                an_n  <= AN_OFF;
                seg_n <= SEG_OFF;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver; the expectation model follows DISP_BLINK_EN too.
`timescale 1ns/1ps

module tb_seg7_scan_driver;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = SCAN_DIV * 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] seg_word = 32'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [5:0]  an_n;

    int          total = 0;
    int          bad = 0;
    int          onehot_viol = 0;
    int          t = 0;
    logic [31:0] model_shadow = 32'h0;
    logic [13:0] exp_q[$];
    logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_driver #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_word (seg_word),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(~an_n) > 1) onehot_viol++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected {an_n, seg_n, dp_n} after the next clock edge, from elapsed edge count.
    task automatic model_step(input logic [31:0] w, output logic [13:0] e);
        int         cnt;
        int         idx;
        logic       phase_off;
        logic       act;
        logic [3:0] nib;
        t++;
        if (t % FRAME == 0) model_shadow = w;
        cnt       = t % SCAN_DIV;
        idx       = (t / SCAN_DIV) % 6;
        phase_off = 1'b0;
`ifdef DISP_BLINK_EN
        phase_off = (((t / FRAME) / BLINK_FRAMES) % 2) == 1;
`endif
        act = (cnt >= BLANK_CYCLES) && model_shadow[31] && !(phase_off && model_shadow[24 + idx]);
        nib = model_shadow[4*idx +: 4];
        if (act) begin
            e[13:8] = 6'h3F & ~(6'h01 << idx);
            e[7:1]  = ~lut[nib];
            e[0]    = !(((idx == 2) || (idx == 4)) && model_shadow[30]);
        end else begin
            e = {6'h3F, 7'h7F, 1'b1};
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w, input int n, input string tag);
        logic [13:0] e;
        logic [13:0] want;
        for (int i = 0; i < n; i++) begin
            seg_word = w;
            model_step(w, e);
            exp_q.push_back(e);
            @(negedge clk);
            want = exp_q.pop_front();
            checkOutput($sformatf("%s t=%0d", tag, t), {an_n, seg_n, dp_n}, want);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_out", {an_n, seg_n, dp_n}, {6'h3F, 7'h7F, 1'b1});
        reset = 1'b0;
        t = 0;
        model_shadow = 32'h0;

        applyStimulus(32'h80123456, 2 * FRAME, "hex_a");
        applyStimulus(32'h80123456, 1, "hex_a");
        checkOutput("slot0_spot", {an_n, seg_n, dp_n}, {6'h3E, ~7'h7D, 1'b1});
        applyStimulus(32'h80123456, 20, "hex_a");
        checkOutput("slot5_spot", {an_n, seg_n, dp_n}, {6'h1F, ~7'h06, 1'b1});
        applyStimulus(32'h80654321, 4, "midframe");
        checkOutput("new_slot0_spot", {an_n, seg_n, dp_n}, {6'h3E, ~7'h06, 1'b1});
        applyStimulus(32'h80654321, FRAME - 1, "midframe");

        applyStimulus(32'hC0000000, 2 * FRAME, "colon");
        applyStimulus(32'h40000000, 2 * FRAME, "disabled");
        applyStimulus(32'h81000000, 5 * FRAME, "blink");

        for (int v = 0; v < 16; v++) begin
            logic [3:0] nv;
            nv = 4'(v);
            applyStimulus({28'h8000000, nv}, FRAME, "sweep");
        end
        applyStimulus(32'h8000000F, FRAME, "sweep");

        applyStimulus(32'h80000005, 6, "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_async", {an_n, seg_n, dp_n}, {6'h3F, 7'h7F, 1'b1});
        seg_word = 32'h80000009;
        @(negedge clk);
        checkOutput("reset_hold", {an_n, seg_n, dp_n}, {6'h3F, 7'h7F, 1'b1});
        reset = 1'b0;
        t = 0;
        model_shadow = 32'h0;
        applyStimulus(32'h80000009, 2 * FRAME, "post_reset");

        checkOutput("an_onehot", onehot_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the 32-bit 7-segment PIO word written by the Nios platform and drives a 6-digit, common-anode, multiplexed 7-segment display (HH:MM:SS for the alarm clock).
- Decodes hex nibbles, time-multiplexes the digits and adds anti-ghost blanking.
- Latches the PIO word only at frame boundaries so a CPU update never shows a half-written display.
- Sits at board top level, between the platform PIO export and the FPGA pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64: full scan frames per blink half-period. Used only with DISP_BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- seg_word  in  32  PIO word, quasi-static.
  - [23:0]: six hex nibbles; nibble 0 is the rightmost digit.
  - [29:24]: per-digit blink mask.
  - [30]: colon enable.
  - [31]: display enable.
- seg_n  out  7  segments a..g, active-low; bit 0 = a.
- dp_n  out  1  decimal point, active-low.
- an_n  out  6  digit anodes, active-low; at most one bit low at any time.

Behaviour:
- Reset (async, active-high) clears:
  - prescaler, digit index and shadow word to 0;
  - blink counter to 0, blink phase to "on".
- Outputs during reset: seg_n=7'h7F, dp_n=1, an_n=6'h3F. They stay there until the first slot's blanking ends.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - A tick occurs on the wrap. On a tick the digit index increments 0..5 and wraps to 0.
- Frame boundary = tick where the index wraps 5→0. On that same edge, shadow <= seg_word.
  - Digit 0 of the new frame shows the new data.
  - seg_word is never sampled at any other time.
  - Display latency for a seg_word change: ≤ 6*SCAN_DIV+1 cycles.
- Outputs are registered from the current index, shadow and prescaler count.
- an_n for the current index is low only when all of these hold:
  - prescaler count ≥ BLANK_CYCLES;
  - shadow[31] = 1;
  - the digit is not blink-suppressed.
  - Otherwise an_n=6'h3F.
- Segment decode is standard hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (active-high a..g).
  - seg_n is the inverse.
- dp_n = 0 only on digit indices 2 and 4 (HH.MM.SS separators), and only while shadow[30]=1 and that anode is active.
- Blanked slot: seg_n=7'h7F, dp_n=1.
- After a reset deassert mid-frame, scanning restarts at digit 0 with shadow = 0. Display stays dark until the first frame boundary latches an enabled word.
- seg_word changes are glitch-safe: input is consumed only through the shadow register. The word comes from a synchronous PIO in the same clk domain, so no synchronizer is needed.

Optional Feature:
- DISP_BLINK_EN defined:
  - A frame counter counts frame boundaries modulo BLINK_FRAMES; on wrap the blink phase toggles.
  - While phase = "off", digits whose shadow[24+i]=1 are blanked: anode off, dp off.
  - Phase and counter reset to "on"/0.
- Undefined: bits [29:24] are ignored, blink logic is absent, all enabled digits are always shown.

Decomposition:
- Package seg7_pkg:
  - constants NUM_DIGITS=6, SEG_OFF=7'h7F, DP_DIGITS mask 6'b010100;
  - typedef digit_idx_t (logic [2:0]);
  - field-position localparams for enable (31), colon (30) and blink (29:24).
- One sub-module: hex_to_seg7, a combinational 4-bit → 7-bit active-high decoder.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2):
- Reset asserted mid-slot → same cycle: an_n=3F, seg_n=7F, dp_n=1. After release, first active digit is index 0 and stays dark: shadow=0, enable=0.
- seg_word=32'h80123456 → after the next frame boundary:
  - slot 0: an_n=3E, seg_n=~7D ("6");
  - slot 5: an_n=1F, seg_n=~06 ("1");
  - cycle 0 of every slot: an_n=3F.
- Change seg_word mid-frame from 8012_3456 to 8065_4321 → remaining digits of the current frame still show the old value; new value appears from the next digit 0.
- seg_word=C0000000 → dp_n=0 only during active slots 2 and 4, all digits show "0". bit31=0 → an_n stays 3F for the whole frame.
- DISP_BLINK_EN, seg_word=81000000 → digit 0 is dark for 2 frames, lit for 2 frames, repeating. Without the macro, digit 0 is lit every frame.
- Exhaustive nibble sweep 0..F on digit 0 → seg_n matches the decode table; an_n never has more than one zero (assertion).
